// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle memory port between the wramp core (port 0)
// and a DMA/debug loader (port 1). Registered owner state, round-robin on ties,
// and a hold limit so a streaming owner cannot starve the other port.
module mem_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_value,
  input  logic [DATA_W-1:0] mem_read_value,
  output logic [1:0]        owner,
  output logic [CNT_W-1:0]  wait_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  // Wide enough to hold MAX_HOLD-1 for any MAX_HOLD >= 1.
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              rr_last;   // 0: port 0 was the last owner, 1: port 1
  logic              rr_nxt;
  logic              hold_at_max;
  logic              wait0;
  logic              wait1;
  logic [1:0]        wait_inc;
  logic [CNT_W:0]    wait_sum;

  assign owner       = state;
  assign hold_at_max = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Acks and read data follow the owner and its live request.
  always_comb begin
    m0_ack   = (state == OWN0) && m0_req;
    m1_ack   = (state == OWN1) && m1_req;
    m0_rdata = m0_ack ? mem_read_value : {DATA_W{1'b0}};
    m1_rdata = m1_ack ? mem_read_value : {DATA_W{1'b0}};
  end

  // Memory bus mux: owner's address/data, bus quiet when idle.
  always_comb begin
    mem_address     = {ADDR_W{1'b0}};
    mem_write_en    = 1'b0;
    mem_write_value = {DATA_W{1'b0}};
    case (state)
      OWN0: begin
        mem_address     = m0_addr;
        mem_write_en    = m0_req && m0_we;
        mem_write_value = m0_wdata;
      end
      OWN1: begin
        mem_address     = m1_addr;
        mem_write_en    = m1_req && m1_we;
        mem_write_value = m1_wdata;
      end
      default: begin
        mem_address     = {ADDR_W{1'b0}};
        mem_write_en    = 1'b0;
        mem_write_value = {DATA_W{1'b0}};
      end
    endcase
  end

  // Ownership transitions: round-robin on ties, hold limit under contention.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    rr_nxt    = rr_last;
    case (state)
      IDLE: begin
        hold_nxt = {HOLD_W{1'b0}};
        if (m0_req && m1_req) begin
          state_nxt = rr_last ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_nxt = OWN0;
        end else if (m1_req) begin
          state_nxt = OWN1;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          state_nxt = m1_req ? OWN1 : IDLE;
          hold_nxt  = {HOLD_W{1'b0}};
          rr_nxt    = 1'b0;
        end else if (m1_req && hold_at_max) begin
          state_nxt = OWN1;
          hold_nxt  = {HOLD_W{1'b0}};
          rr_nxt    = 1'b0;
        end else begin
          hold_nxt  = m1_req ? (hold_cnt + HOLD_W'(1)) : {HOLD_W{1'b0}};
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_nxt = m0_req ? OWN0 : IDLE;
          hold_nxt  = {HOLD_W{1'b0}};
          rr_nxt    = 1'b1;
        end else if (m0_req && hold_at_max) begin
          state_nxt = OWN0;
          hold_nxt  = {HOLD_W{1'b0}};
          rr_nxt    = 1'b1;
        end else begin
          hold_nxt  = m0_req ? (hold_cnt + HOLD_W'(1)) : {HOLD_W{1'b0}};
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = {HOLD_W{1'b0}};
        rr_nxt    = 1'b1;
      end
    endcase
  end

  // Saturating wait counter: one count per port per stalled cycle.
  always_comb begin
    wait0    = m0_req && !m0_ack;
    wait1    = m1_req && !m1_ack;
    wait_inc = {1'b0, wait0} + {1'b0, wait1};
    wait_sum = {1'b0, wait_cnt} + {{(CNT_W-1){1'b0}}, wait_inc};
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state    <= IDLE;
      hold_cnt <= {HOLD_W{1'b0}};
      rr_last  <= 1'b1;
      wait_cnt <= {CNT_W{1'b0}};
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      rr_last  <= rr_nxt;
      wait_cnt <= wait_sum[CNT_W] ? {CNT_W{1'b1}} : wait_sum[CNT_W-1:0];
    end
  end

endmodule
